// File: rtl/ef_uart_pkg.sv
// Shared constants for the UART receive path: parity modes, FSM states, size limits.
package ef_uart_pkg;

    // parity_type encodings; unlisted codes behave as none
    localparam logic [2:0] PAR_NONE   = 3'b000;
    localparam logic [2:0] PAR_ODD    = 3'b001;
    localparam logic [2:0] PAR_EVEN   = 3'b010;
    localparam logic [2:0] PAR_STICK0 = 3'b100;
    localparam logic [2:0] PAR_STICK1 = 3'b101;

    // receive FSM states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // smallest supported character size
    localparam int unsigned DSZ_MIN = 5;

    // True when the mode carries a parity bit on the line
    function automatic logic par_enabled(input logic [2:0] pt);
        return (pt == PAR_ODD) || (pt == PAR_EVEN) ||
               (pt == PAR_STICK0) || (pt == PAR_STICK1);
    endfunction

endpackage

// File: rtl/ef_uart_sync.sv
// Two-flop synchronizer for the asynchronous RX pin; resets to the idle-high level.
module ef_uart_sync
    import ef_uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // shift the pin through two flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/ef_uart_rx_core.sv
// 16x oversampled UART receive engine: start/data/parity/stop sampling and FIFO write strobe.
module ef_uart_rx_core
    import ef_uart_pkg::*;
#(
    parameter int unsigned MDW = 9,
    parameter int unsigned OS  = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           tick,
    input  logic           rx,
    input  logic [3:0]     data_size,
    input  logic           stop_bits,
    input  logic [2:0]     parity_type,
    output logic [MDW-1:0] dout,
    output logic           rx_done,
    output logic           parity_err,
    output logic           frame_err,
    output logic           break_det,
    output logic           busy
);

    localparam int unsigned SW = $clog2(OS);

    logic           rx_s;
    logic [2:0]     state_q, state_d;
    logic [SW-1:0]  s_q, s_d;
    logic [3:0]     n_q, n_d;
    logic [MDW-1:0] sr_q, sr_d;
    logic [3:0]     dsz_q, dsz_d, dsz_clamp;
    logic           stop2_q, stop2_d;
    logic [2:0]     par_q, par_d;
    logic           first_stop_q, first_stop_d;
    logic           perr_acc_q, perr_acc_d;
    logic           ferr_acc_q, ferr_acc_d;
    logic           pbit_q, pbit_d;
    logic           wait_high_q, wait_high_d;
    logic [MDW-1:0] dout_q, dout_d;
    logic           rx_done_q, rx_done_d;
    logic           parity_err_q, parity_err_d;
    logic           frame_err_q, frame_err_d;
    logic           break_det_q, break_det_d;
    logic           busy_q;
    logic           fe_now;
    logic [3:0]     shamt;

    ef_uart_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    // clamp the requested character size into DSZ_MIN..MDW
    always_comb begin
        if (data_size < 4'(DSZ_MIN))  dsz_clamp = 4'(DSZ_MIN);
        else if (data_size > 4'(MDW)) dsz_clamp = 4'(MDW);
        else                          dsz_clamp = data_size;
    end

    assign shamt  = 4'(MDW) - dsz_q;
    assign fe_now = ferr_acc_q | ~rx_s;

    // next-state and datapath for the receive FSM
    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        sr_d         = sr_q;
        dsz_d        = dsz_q;
        stop2_d      = stop2_q;
        par_d        = par_q;
        first_stop_d = first_stop_q;
        perr_acc_d   = perr_acc_q;
        ferr_acc_d   = ferr_acc_q;
        pbit_d       = pbit_q;
        wait_high_d  = wait_high_q & ~rx_s;
        dout_d       = dout_q;
        rx_done_d    = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        break_det_d  = break_det_q;

        if (!en) begin
            state_d = ST_IDLE;
            s_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // a line still low after a low stop sample is not a new start edge
                    if (!rx_s && !wait_high_q) begin
                        state_d = ST_START;
                        s_d     = '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (s_q == SW'(OS/2 - 1)) begin
                            s_d = '0;
                            if (!rx_s) begin
                                state_d      = ST_DATA;
                                n_d          = 4'd0;
                                sr_d         = '0;
                                dsz_d        = dsz_clamp;
                                stop2_d      = stop_bits;
                                par_d        = parity_type;
                                first_stop_d = 1'b1;
                                perr_acc_d   = 1'b0;
                                ferr_acc_d   = 1'b0;
                                pbit_d       = 1'b0;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            s_d = s_q + SW'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (s_q == SW'(OS - 1)) begin
                            s_d  = '0;
                            sr_d = {rx_s, sr_q[MDW-1:1]};
                            n_d  = n_q + 4'd1;
                            if (n_q == dsz_q - 4'd1)
                                state_d = par_enabled(par_q) ? ST_PARITY : ST_STOP;
                        end else begin
                            s_d = s_q + SW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        if (s_q == SW'(OS - 1)) begin
                            s_d     = '0;
                            pbit_d  = rx_s;
                            state_d = ST_STOP;
                            case (par_q)
                                PAR_ODD:    perr_acc_d = ~((^sr_q) ^ rx_s);
                                PAR_EVEN:   perr_acc_d = (^sr_q) ^ rx_s;
                                PAR_STICK0: perr_acc_d = rx_s;
                                PAR_STICK1: perr_acc_d = ~rx_s;
                                default:    perr_acc_d = 1'b0;
                            endcase
                        end else begin
                            s_d = s_q + SW'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (s_q == SW'(OS - 1)) begin
                            s_d = '0;
                            if (stop2_q && first_stop_q) begin
                                first_stop_d = 1'b0;
                                ferr_acc_d   = fe_now;
                            end else begin
                                state_d      = ST_IDLE;
                                rx_done_d    = 1'b1;
                                wait_high_d  = ~rx_s;
                                dout_d       = sr_q >> shamt;
                                parity_err_d = perr_acc_q;
                                frame_err_d  = fe_now;
                                break_det_d  = fe_now && (sr_q == '0) &&
                                               (!par_enabled(par_q) || !pbit_q);
                            end
                        end else begin
                            s_d = s_q + SW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    s_d     = '0;
                end
            endcase
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            s_q          <= '0;
            n_q          <= '0;
            sr_q         <= '0;
            dsz_q        <= 4'(DSZ_MIN);
            stop2_q      <= 1'b0;
            par_q        <= PAR_NONE;
            first_stop_q <= 1'b0;
            perr_acc_q   <= 1'b0;
            ferr_acc_q   <= 1'b0;
            pbit_q       <= 1'b0;
            wait_high_q  <= 1'b0;
            dout_q       <= '0;
            rx_done_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_det_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            n_q          <= n_d;
            sr_q         <= sr_d;
            dsz_q        <= dsz_d;
            stop2_q      <= stop2_d;
            par_q        <= par_d;
            first_stop_q <= first_stop_d;
            perr_acc_q   <= perr_acc_d;
            ferr_acc_q   <= ferr_acc_d;
            pbit_q       <= pbit_d;
            wait_high_q  <= wait_high_d;
            dout_q       <= dout_d;
            rx_done_q    <= rx_done_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            break_det_q  <= break_det_d;
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    assign dout       = dout_q;
    assign rx_done    = rx_done_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign break_det  = break_det_q;
    assign busy       = busy_q;

endmodule
